// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer: owns every pipeline enable and flush.
// Optional perf counters enabled by `define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  input  logic       branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_flush_lwstall,
  output logic       pipe_freeze,
  output logic       wb_bubble,
  output logic       init_busy,
  output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_WAIT,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;

  logic lu_hazard;
  logic mem_stall;
  logic run_dec;

  always_comb begin
    lu_hazard = ex_memread && (ex_rd != 5'd0) &&
                ((ex_rd == id_rs1) ||
                 (id_uses_rs2 && (ex_rd == id_rs2)));
    mem_stall = mem_req && !mem_ready;
  end

  always_comb begin
    state_d          = state_q;
    init_cnt_d       = init_cnt_q;
    wait_cnt_d       = wait_cnt_q;
    run_dec          = 1'b0;
    pc_write         = 1'b0;
    if_id_write      = 1'b0;
    if_id_flush      = 1'b0;
    id_flush_lwstall = 1'b0;
    pipe_freeze      = 1'b0;
    wb_bubble        = 1'b0;
    init_busy        = 1'b0;
    mem_timeout      = 1'b0;
    case (state_q)
      S_INIT: begin
        pipe_freeze = 1'b1;
        wb_bubble   = 1'b1;
        init_busy   = 1'b1;
        init_cnt_d  = init_cnt_q + 1'b1;
        if (init_cnt_q == IW'(INIT_CYCLES - 1))
          state_d = S_RUN;
      end
      S_RUN: begin
        if (mem_stall) begin
          pipe_freeze = 1'b1;
          wb_bubble   = 1'b1;
          wait_cnt_d  = WW'(1);
          state_d     = S_WAIT;
        end else begin
          run_dec = 1'b1;
        end
      end
      S_WAIT: begin
        // wait_cnt holds frozen cycles already spent before this one
        if (mem_stall) begin
          pipe_freeze = 1'b1;
          wb_bubble   = 1'b1;
          wait_cnt_d  = wait_cnt_q + 1'b1;
          if (wait_cnt_q == WW'(MEM_TIMEOUT - 1))
            state_d = S_ERR;
        end else begin
          run_dec = 1'b1;
          state_d = S_RUN;
        end
      end
      default: begin
        pipe_freeze = 1'b1;
        wb_bubble   = 1'b1;
        mem_timeout = 1'b1;
      end
    endcase
    if (run_dec) begin
      priority case (1'b1)
        lu_hazard: begin
          id_flush_lwstall = 1'b1;
        end
        branch_taken: begin
          if_id_flush = 1'b1;
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
        default: begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_stall_cnt_q, lu_stall_cnt_d;
  logic [CNT_W-1:0] mem_wait_cnt_q, mem_wait_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             mw_inc;

  always_comb begin
    lu_stall_cnt_d = lu_stall_cnt_q;
    mem_wait_cnt_d = mem_wait_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    mw_inc = pipe_freeze &&
             ((state_q == S_RUN) || (state_q == S_WAIT));
    if (id_flush_lwstall && !(&lu_stall_cnt_q))
      lu_stall_cnt_d = lu_stall_cnt_q + 1'b1;
    if (mw_inc && !(&mem_wait_cnt_q))
      mem_wait_cnt_d = mem_wait_cnt_q + 1'b1;
    if (if_id_flush && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lu_stall_cnt_q <= '0;
      mem_wait_cnt_q <= '0;
      flush_cnt_q    <= '0;
    end else begin
      lu_stall_cnt_q <= lu_stall_cnt_d;
      mem_wait_cnt_q <= mem_wait_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign lu_stall_cnt = lu_stall_cnt_q;
  assign mem_wait_cnt = mem_wait_cnt_q;
  assign flush_cnt    = flush_cnt_q;
`endif

endmodule
